xnor_prbs_checker: RTL and testbench
====================================

// Module: xnor_prbs_checker
// PURPOSE
//  Serial PRBS checker, receive end of the team's XNOR-feedback LFSR pattern source.
//  Self-synchronises to an incoming 1-bit stream, declares lock, then counts bit errors.
//  Sits at the receive side of loopback/link tests; single clock domain.
// PARAMETERS
//  PRBS_ORDER  7   LFSR length; legal 7,9,15,23,31 (XNOR taps 7/6, 9/5, 15/14, 23/18, 31/28)
//  LOCK_CNT    16  consecutive matching beats in ACQUIRE needed to declare lock
//  LOSS_CNT    4   consecutive mismatches in LOCKED that drop lock
//  ERR_W       16  width of saturating error counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      qualifies in_bit; all state advances only when 1
//  in_bit     in   1      received serial bit
//  clr_cnt    in   1      synchronous clear of err_count
//  locked     out  1      pattern lock indicator
//  err_pulse  out  1      one-cycle pulse per mismatch while LOCKED
//  err_count  out  ERR_W  saturating mismatch count (LOCKED only)
// BEHAVIOUR
//  - Reset: state=SEED, sr=0, seed_cnt=0, match_cnt=0, loss_cnt=0, locked=0, err_pulse=0, err_count=0.
//  - sr[0] = newest bit. pred = ~(sr[TA-1] ^ sr[TB-1]) for taps TA/TB of PRBS_ORDER.
//  - in_valid=0: every register holds; err_pulse forced 0 that cycle.
//  - SEED: sr <= {sr[N-2:0],in_bit}; after PRBS_ORDER valid beats -> ACQUIRE (match_cnt=0).
//  - ACQUIRE: compare in_bit to pred, shift in in_bit (self-sync). Match: match_cnt++;
//    reaching LOCK_CNT -> LOCKED. Mismatch: -> SEED, seed_cnt=0, match_cnt=0. No err counting.
//  - LOCKED: shift in pred (free-running reference, one flip = one error). Mismatch:
//    err_pulse=1, err_count+1 (saturates at 2^ERR_W-1), loss_cnt++; reaching LOSS_CNT -> SEED,
//    locked=0. Match: loss_cnt=0.
//  - Outputs registered: locked/err_pulse valid the cycle after the causing valid beat.
//  - clr_cnt with simultaneous counted error: err_count=1 (clear, then count). clr_cnt alone: 0.
//  - rst mid-operation: immediate return to reset values next edge, lock lost.
// CONFIGURATION
//  XNOR_PRBS_LOCKUP_DET_EN defined: extra output stuck (1 bit, reset 0). In SEED/ACQUIRE, an
//    all-ones sr (XNOR lockup state) forces state=SEED, seed_cnt=0, stuck=1; stuck clears on the
//    first valid beat where sr is not all-ones. LOCKED is never entered from all-ones.
//  Not defined: no stuck port; all-ones stream self-matches and declares lock.
// STRUCTURE
//  Package xnor_prbs_pkg: state enum {SEED,ACQUIRE,LOCKED}; function returning tap pair per
//    order; legal-order check used by an elaboration-time assertion.
//  One sub-module: sat_counter (WIDTH, inc, clr, count) for err_count.
// TESTING
//  1 Reset, feed clean PRBS7 from XNOR generator seeded 0 -> locked=1 after beat 23 (7+16), err_count=0.
//  2 After lock, invert one bit -> one err_pulse, err_count=1, locked stays 1.
//  3 After lock, invert 4 consecutive bits -> err_count=4, locked=0; 23 clean beats -> relock.
//  4 Random in_valid gaps (~50%) on test 1 stream -> lock after exactly 23 valid beats.
//  5 clr_cnt same beat as error -> err_count=1; ERR_W=4 with 20 errors -> err_count=15.
//  6 All-ones stream: macro on -> stuck=1, locked=0; macro off -> locked=1 after beat 23.

Source files
------------

// File: rtl/xnor_prbs_pkg.sv
// xnor_prbs_pkg: shared states, tap table and order check for the XNOR PRBS checker
package xnor_prbs_pkg;
  typedef enum logic [1:0] {SEED, ACQUIRE, LOCKED} state_e;
  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
  } taps_t;
  function automatic taps_t prbs_taps(input int order);
    return (order == 9)  ? taps_t'{5'd9,  5'd5}  :
           (order == 15) ? taps_t'{5'd15, 5'd14} :
           (order == 23) ? taps_t'{5'd23, 5'd18} :
           (order == 31) ? taps_t'{5'd31, 5'd28} : taps_t'{5'd7, 5'd6};
  endfunction
  function automatic bit legal_order(input int order);
    return order inside {7, 9, 15, 23, 31};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that still honours a same-cycle increment
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = clr ? WIDTH'(inc) : (inc && !(&count_q)) ? count_q + WIDTH'(1) : count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/xnor_prbs_checker.sv
// xnor_prbs_checker: self-synchronising XNOR PRBS receiver with lock detection and error counting.
// XNOR_PRBS_LOCKUP_DET_EN adds a stuck output that refuses lock on the all-ones lockup state.
module xnor_prbs_checker
  import xnor_prbs_pkg::*;
#(
  parameter int PRBS_ORDER = 7,
  parameter int LOCK_CNT   = 16,
  parameter int LOSS_CNT   = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
`ifdef XNOR_PRBS_LOCKUP_DET_EN
  ,output logic            stuck
`endif
);
  localparam int    N    = PRBS_ORDER;
  localparam taps_t TAPS = prbs_taps(PRBS_ORDER);
  localparam int    TA   = int'(TAPS.a);
  localparam int    TB   = int'(TAPS.b);
  localparam int    SW   = $clog2(N);
  localparam int    MW   = $clog2(LOCK_CNT + 1);
  localparam int    LW   = $clog2(LOSS_CNT + 1);
  if (!legal_order(PRBS_ORDER)) begin : g_bad_order
    $error("xnor_prbs_checker: unsupported PRBS_ORDER %0d", PRBS_ORDER);
  end
  state_e         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [SW-1:0]  seed_cnt_q, seed_cnt_d;
  logic [MW-1:0]  match_cnt_q, match_cnt_d;
  logic [LW-1:0]  loss_cnt_q, loss_cnt_d;
  logic           err_pulse_q, err_pulse_d;
  logic           pred, miss, lockup;
  assign pred = ~(sr_q[TA-1] ^ sr_q[TB-1]);
  assign miss = in_bit ^ pred;
`ifdef XNOR_PRBS_LOCKUP_DET_EN
  logic stuck_q;
  assign lockup = &sr_q;
  always_ff @(posedge clk) begin
    if (rst)           stuck_q <= 1'b0;
    else if (in_valid) stuck_q <= lockup && state_q != LOCKED;
  end
  assign stuck = stuck_q;
`else
  assign lockup = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    err_pulse_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEED: begin
          sr_d       = {sr_q[N-2:0], in_bit};
          seed_cnt_d = seed_cnt_q + SW'(1);
          if (seed_cnt_q == SW'(N - 1)) begin
            state_d     = ACQUIRE;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end
        end
        ACQUIRE: begin
          sr_d        = {sr_q[N-2:0], in_bit};
          match_cnt_d = match_cnt_q + MW'(1);
          if (miss) begin
            state_d     = SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            loss_cnt_d  = '0;
          end
        end
        LOCKED: begin
          // free-running reference so a single flipped bit costs exactly one error
          sr_d        = {sr_q[N-2:0], pred};
          err_pulse_d = miss;
          loss_cnt_d  = miss ? loss_cnt_q + LW'(1) : '0;
          if (miss && loss_cnt_q == LW'(LOSS_CNT - 1)) begin
            state_d    = SEED;
            seed_cnt_d = '0;
            loss_cnt_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
      if (lockup && state_q != LOCKED) begin
        state_d     = SEED;
        seed_cnt_d  = '0;
        match_cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      sr_q        <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      loss_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end
  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (in_valid && state_q == LOCKED && miss),
    .clr  (in_valid && clr_cnt),
    .count(err_count)
  );
  assign locked    = state_q == LOCKED;
  assign err_pulse = err_pulse_q;
endmodule

// File: tb/tb_xnor_prbs_checker.sv
// tb_xnor_prbs_checker: scoreboard bench driving a PRBS7 XNOR stream into a default and a 4-bit-counter checker
module tb_xnor_prbs_checker;
  typedef struct {
    logic        lk;
    logic        ep;
    logic [15:0] c;
    logic [3:0]  c4;
    logic        st;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
`ifdef XNOR_PRBS_LOCKUP_DET_EN
  logic        stuck, stuck4;
`endif
  logic        v_q = 1'b0;
  logic [6:0]  g = '0;
  exp_t        q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  xnor_prbs_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef XNOR_PRBS_LOCKUP_DET_EN
    , .stuck(stuck)
`endif
  );
  xnor_prbs_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
`ifdef XNOR_PRBS_LOCKUP_DET_EN
    , .stuck(stuck4)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic gen_bit();
    logic b;
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
    return b;
  endfunction
  always @(posedge clk) v_q <= in_valid && !rst;
  always @(negedge clk) begin
    if (v_q) begin
      if (q.size() == 0) chk("queue_underrun", 1, 0);
      else begin
        e = q.pop_front();
        chk("locked", locked, e.lk);
        chk("err_pulse", err_pulse, e.ep);
        chk("err_count", err_count, e.c);
        chk("locked_w4", locked4, e.lk);
        chk("err_count_w4", err_count4, e.c4);
`ifdef XNOR_PRBS_LOCKUP_DET_EN
        chk("stuck", stuck, e.st);
`endif
      end
    end else begin
      chk("err_pulse_idle", err_pulse, 0);
    end
  end
  task automatic beat(input logic b, input logic c, input logic lk, input logic ep,
                      input int cnt, input logic st);
    exp_t x;
    x.lk = lk;
    x.ep = ep;
    x.c  = 16'(cnt);
    x.c4 = cnt > 15 ? 4'd15 : 4'(cnt);
    x.st = st;
    q.push_back(x);
    in_valid = 1'b1;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic reset_dut();
    rst      = 1'b1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    g   = '0;
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_count_w4", err_count4, 0);
`ifdef XNOR_PRBS_LOCKUP_DET_EN
    chk("rst_stuck", stuck, 0);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    idle(1);
    // clean stream locks after 7 seed + 16 matching beats
    reset_dut();
    for (int i = 1; i <= 30; i++) beat(gen_bit(), 1'b0, i >= 23, 1'b0, 0, 1'b0);
    // single inverted bit: one error, lock kept
    beat(~gen_bit(), 1'b0, 1'b1, 1'b1, 1, 1'b0);
    for (int i = 0; i < 5; i++) beat(gen_bit(), 1'b0, 1'b1, 1'b0, 1, 1'b0);
    // four consecutive errors drop lock, then relock on clean data
    reset_dut();
    for (int i = 1; i <= 23; i++) beat(gen_bit(), 1'b0, i >= 23, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 4; k++) beat(~gen_bit(), 1'b0, k < 4, 1'b1, k, 1'b0);
    for (int i = 1; i <= 23; i++) beat(gen_bit(), 1'b0, i >= 23, 1'b0, 4, 1'b0);
    // random valid gaps must not change the beat count to lock
    reset_dut();
    n = 0;
    while (n < 30) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      n++;
      beat(gen_bit(), 1'b0, n >= 23, 1'b0, 0, 1'b0);
    end
    // clear coinciding with an error yields 1; 20 spaced errors saturate the 4-bit counter
    beat(~gen_bit(), 1'b1, 1'b1, 1'b1, 1, 1'b0);
    for (int k = 2; k <= 20; k++) begin
      beat(gen_bit(), 1'b0, 1'b1, 1'b0, k - 1, 1'b0);
      beat(~gen_bit(), 1'b0, 1'b1, 1'b1, k, 1'b0);
    end
    beat(gen_bit(), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    beat(gen_bit(), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    // all-ones stream: lockup state
    reset_dut();
    for (int i = 1; i <= 30; i++) begin
`ifdef XNOR_PRBS_LOCKUP_DET_EN
      beat(1'b1, 1'b0, 1'b0, 1'b0, 0, i >= 8);
`else
      beat(1'b1, 1'b0, i >= 23, 1'b0, 0, 1'b0);
`endif
    end
    // reset while running returns everything to idle
    reset_dut();
    idle(2);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
